egress_sink: RTL
================

Name: egress_sink

Overview:
- Read-side endpoint for one hydra output port; consumes the rd_sop/rd_vld/rd_data/rd_eop stream and drives that port's ready bit.
- Requests one packet at a time and parses the header word: [15:7] length, [6:4] priority, [3:0] destination port.
- Streams the payload out and reports per-packet status and error flags.
- Instantiated once per port on the egress side of hydra, and also used as the bench's scoreboard sink.

Parameters:
- PORT_ID, 0, destination port number (0-15) that this sink expects in headers.
- TIMEOUT, 64, cycles to wait for rd_sop after a request before abandoning it.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  permission to issue new packet requests.
- ready  out  1  one-cycle packet request pulse to the switch.
- rd_sop  in  1  packet start pulse; carries no data.
- rd_eop  in  1  packet end pulse; may coincide with the last rd_vld.
- rd_vld  in  1  rd_data valid.
- rd_data  in  16  header or payload word.
- out_vld  out  1  payload word valid.
- out_data  out  16  payload word.
- out_first  out  1  marks the first payload word of a packet.
- pkt_done  out  1  one-cycle end-of-packet status strobe.
- pkt_len  out  9  payload words actually received.
- pkt_prio  out  3  header priority.
- pkt_dest  out  4  header destination.
- len_err  out  1  received word count differs from the header length (valid with pkt_done).
- dest_err  out  1  header destination differs from PORT_ID (valid with pkt_done).
- proto_err  out  1  one-cycle pulse on a protocol violation.
- req_timeout  out  1  one-cycle pulse when a request is abandoned.
- pkt_cnt  out  16  completed packets; wraps.
- err_cnt  out  16  packets with any error; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs and counters 0; state IDLE; asynchronous assert, synchronous release on clk.
- States and transitions:
  - IDLE: go to REQ when en=1.
  - REQ: ready=1 for exactly one cycle; go to WAIT_SOP; load timer with TIMEOUT.
  - WAIT_SOP:
    - rd_sop -> HDR.
    - Timer reaches 0 -> req_timeout pulse, return to IDLE (re-requests next cycle if en=1).
    - rd_vld or rd_eop seen -> proto_err pulse; input ignored.
  - HDR:
    - First rd_vld latches pkt_len target, pkt_prio and pkt_dest -> BODY; word_cnt=0.
    - rd_eop before any header -> proto_err, packet discarded, return to IDLE.
  - BODY:
    - Each rd_vld: out_vld=1, out_data=rd_data, word_cnt++; word_cnt saturates at 511.
    - out_first=1 on the first payload word only.
    - rd_eop -> DONE; an rd_vld in the same cycle is counted first.
    - Header length 0 is legal: wait for rd_eop.
  - DONE: pkt_done=1 for one cycle with pkt_len=word_cnt, len_err and dest_err; pkt_cnt++; err_cnt++ if either flag is set; go to IDLE.
- rd_sop while in HDR or BODY:
  - proto_err pulse.
  - Current packet closes with pkt_done, len_err forced to 1.
  - Go to HDR: the new sop starts a fresh packet, and no request is issued for it.
- Simultaneous rd_sop and rd_vld in WAIT_SOP: sop is taken, the vld word is ignored, and proto_err is raised.
- Latency: out_* is registered, one cycle after rd_vld. pkt_done comes one cycle after rd_eop.
- en=0 does not abort a packet in flight; it only blocks the IDLE->REQ transition.
- ready is never high outside REQ.
- No backpressure on out_*.

Optional Feature:
- Macro: EGRESS_SINK_CSUM_EN.
- With the macro defined:
  - Adds output pkt_csum (16 bits), the XOR of all payload words of the packet, valid with pkt_done; it is cleared on entry to HDR.
  - Adds input exp_csum (16 bits). A mismatch at DONE sets a csum_err output and counts into err_cnt.
- Without the macro: these ports and all related logic are absent.

Decomposition:
- Package egress_pkg holds:
  - hdr_t packed struct {len[8:0], prio[2:0], dest[3:0]}.
  - state enum {IDLE, REQ, WAIT_SOP, HDR, BODY, DONE}.
  - Constants HDR_LEN_W=9, PORT_W=4.
- Sub-module egress_csum_acc, instantiated only under EGRESS_SINK_CSUM_EN.

Test Plan:
- Normal packet, PORT_ID=3, en=1:
  - Stimulus: switch answers ready with rd_sop 2 cycles later, then header 16'h0FC3 followed by 31 payload words 1..31, rd_eop on the cycle after the last word.
  - Response: ready pulses once; 31 out_vld, out_first on word 1; pkt_done with pkt_len=31, pkt_prio=4, pkt_dest=3, len_err=0, dest_err=0; pkt_cnt=1.
- Length mismatch:
  - Stimulus: header 16'h0FC3 followed by 30 payload words.
  - Response: pkt_len=30, len_err=1, err_cnt=1.
- Wrong destination:
  - Stimulus: header 16'h1143 (len 34, prio 4, dest 3) to a PORT_ID=5 instance, 34 payload words.
  - Response: dest_err=1, len_err=0.
- Timeout:
  - Stimulus: no rd_sop for 64 cycles after ready.
  - Response: req_timeout pulses; ready pulses again 2 cycles later.
- Protocol violations:
  - Stimulus: rd_vld in WAIT_SOP -> Response: proto_err, no out_vld.
  - Stimulus: rd_sop mid-BODY after 5 payload words -> Response: pkt_done with pkt_len=5, len_err=1, then the new packet is parsed.
- Reset mid-packet:
  - Stimulus: rst_n low during BODY.
  - Response: all outputs and counters 0 immediately; a new request is issued after release.

Source files
------------

// File: rtl/egress_pkg.sv
// ---------------------------------------------------------------------------
// egress_pkg
// Shared types and constants for the egress sink.
//   hdr_t   : header word layout {len[8:0], prio[2:0], dest[3:0]}
//   state_t : sink control states
// ---------------------------------------------------------------------------
package egress_pkg;

  localparam int HDR_LEN_W = 9;
  localparam int PORT_W    = 4;
  localparam int PRIO_W    = 3;
  localparam int DATA_W    = 16;

  typedef struct packed {
    logic [HDR_LEN_W-1:0] len;
    logic [PRIO_W-1:0]    prio;
    logic [PORT_W-1:0]    dest;
  } hdr_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_SOP,
    HDR,
    BODY,
    DONE
  } state_t;

endpackage

// File: rtl/egress_sink_csum_acc.sv
// ---------------------------------------------------------------------------
// egress_csum_acc
// Running XOR of the payload words of one packet.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : clear the accumulator (packet start)
//   vld_i, data_i  : payload word to fold in
//   acc_next_o     : accumulator value including the word presented this cycle
// ---------------------------------------------------------------------------
module egress_csum_acc
  import egress_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] acc_next_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // acc_next_o is taken before the clear so a packet closed by a new sop
  // still reports its own checksum.
  always_comb begin
    acc_next_o = vld_i ? (acc_q ^ data_i) : acc_q;
    acc_d      = clr_i ? '0 : acc_next_o;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/egress_sink.sv
// ---------------------------------------------------------------------------
// egress_sink
// Read-side endpoint for one hydra output port. Requests one packet at a
// time, parses the header word, streams the payload out and reports
// per-packet status, error flags and counters.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : allow new packet requests
//   ready               : one-cycle request pulse to the switch
//   rd_sop/rd_eop       : packet start / end pulses
//   rd_vld/rd_data      : header or payload word
//   out_vld/out_data    : registered payload word
//   out_first           : first payload word of a packet
//   pkt_done            : one-cycle end-of-packet status strobe
//   pkt_len/prio/dest   : received word count, header priority/destination
//   len_err/dest_err    : status flags, valid with pkt_done
//   proto_err           : pulse on a protocol violation
//   req_timeout         : pulse when a request is abandoned
//   pkt_cnt/err_cnt     : completed packets (wraps) / errored packets (sat)
// Optional (macro EGRESS_SINK_CSUM_EN):
//   exp_csum            : expected payload XOR, sampled at packet close
//   pkt_csum/csum_err   : payload XOR and mismatch flag, valid with pkt_done
// ---------------------------------------------------------------------------
module egress_sink
  import egress_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 ready,
  input  logic                 rd_sop,
  input  logic                 rd_eop,
  input  logic                 rd_vld,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 out_vld,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_first,
  output logic                 pkt_done,
  output logic [HDR_LEN_W-1:0] pkt_len,
  output logic [PRIO_W-1:0]    pkt_prio,
  output logic [PORT_W-1:0]    pkt_dest,
  output logic                 len_err,
  output logic                 dest_err,
  output logic                 proto_err,
  output logic                 req_timeout,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          err_cnt
`ifdef EGRESS_SINK_CSUM_EN
  ,
  input  logic [DATA_W-1:0]    exp_csum,
  output logic [DATA_W-1:0]    pkt_csum,
  output logic                 csum_err
`endif
);

  localparam int                TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PORT_W-1:0] MY_PORT = PORT_W'(PORT_ID);

  function automatic logic [HDR_LEN_W-1:0] sat_inc_len(input logic [HDR_LEN_W-1:0] v,
                                                       input logic inc);
    return (inc && (v != '1)) ? v + HDR_LEN_W'(1) : v;
  endfunction

  function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [HDR_LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                  first_q, first_d;
  hdr_t                  hdr_q, hdr_d, hdr_in;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  out_first_q, out_first_d;
  logic                  proto_q, proto_d;
  logic                  done_q;
  logic [HDR_LEN_W-1:0]  pkt_len_q;
  logic                  len_err_q, dest_err_q;
  logic [15:0]           pkt_cnt_q, err_cnt_q;

  logic                  tmo, close, enter_hdr, csum_mis, any_err;
  logic [HDR_LEN_W-1:0]  fin_len;
  logic                  fin_len_err, fin_dest_err;

  assign hdr_in  = hdr_t'(rd_data);
  assign cnt_inc = sat_inc_len(cnt_q, rd_vld);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    hdr_d        = hdr_q;
    out_vld_d    = 1'b0;
    out_data_d   = out_data_q;
    out_first_d  = 1'b0;
    proto_d      = 1'b0;
    tmo          = 1'b0;
    close        = 1'b0;
    enter_hdr    = 1'b0;
    fin_len      = cnt_q;
    fin_len_err  = 1'b0;
    fin_dest_err = 1'b0;
    case (state_q)
      IDLE: if (en) state_d = REQ;
      REQ: begin
        timer_d = TMR_W'(TIMEOUT);
        state_d = WAIT_SOP;
      end
      WAIT_SOP: begin
        // data or eop before sop is a violation; a vld coinciding with the
        // sop is dropped and flagged the same way
        proto_d = rd_vld | rd_eop;
        if (rd_sop) begin
          state_d   = HDR;
          enter_hdr = 1'b1;
        end else if (timer_q == '0) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      HDR: begin
        if (rd_sop) begin
          // restart before any header: close an empty, short packet
          proto_d     = 1'b1;
          close       = 1'b1;
          fin_len     = '0;
          fin_len_err = 1'b1;
          enter_hdr   = 1'b1;
        end else if (rd_vld) begin
          hdr_d   = hdr_in;
          first_d = 1'b1;
          cnt_d   = '0;
          if (rd_eop) begin
            // header and eop together: a packet with no payload
            close        = 1'b1;
            fin_len      = '0;
            fin_len_err  = (hdr_in.len != '0);
            fin_dest_err = (hdr_in.dest != MY_PORT);
            state_d      = DONE;
          end else begin
            state_d = BODY;
          end
        end else if (rd_eop) begin
          proto_d = 1'b1;
          state_d = IDLE;
        end
      end
      BODY: begin
        if (rd_vld) begin
          out_vld_d   = 1'b1;
          out_data_d  = rd_data;
          out_first_d = first_q;
          first_d     = 1'b0;
          cnt_d       = cnt_inc;
        end
        // a word arriving with eop/sop belongs to the closing packet
        fin_len      = cnt_inc;
        fin_len_err  = (cnt_inc != hdr_q.len);
        fin_dest_err = (hdr_q.dest != MY_PORT);
        if (rd_sop) begin
          proto_d     = 1'b1;
          close       = 1'b1;
          fin_len_err = 1'b1;
          enter_hdr   = 1'b1;
          state_d     = HDR;
        end else if (rd_eop) begin
          close   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_hdr) cnt_d = '0;
  end

`ifdef EGRESS_SINK_CSUM_EN
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] pkt_csum_q;
  logic              csum_err_q;
  logic              acc_vld;

  assign acc_vld = (state_q == BODY) && rd_vld;

  egress_csum_acc u_csum (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .clr_i      (enter_hdr),
    .vld_i      (acc_vld),
    .data_i     (rd_data),
    .acc_next_o (acc_next)
  );

  assign csum_mis = (acc_next != exp_csum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_csum_q <= '0;
      csum_err_q <= 1'b0;
    end else if (close) begin
      pkt_csum_q <= acc_next;
      csum_err_q <= csum_mis;
    end
  end

  assign pkt_csum = pkt_csum_q;
  assign csum_err = csum_err_q;
`else
  assign csum_mis = 1'b0;
`endif

  assign any_err = fin_len_err | fin_dest_err | csum_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      hdr_q       <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      proto_q     <= 1'b0;
      done_q      <= 1'b0;
      pkt_len_q   <= '0;
      len_err_q   <= 1'b0;
      dest_err_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      hdr_q       <= hdr_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      proto_q     <= proto_d;
      done_q      <= close;
      if (close) begin
        pkt_len_q  <= fin_len;
        len_err_q  <= fin_len_err;
        dest_err_q <= fin_dest_err;
        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
        if (any_err) err_cnt_q <= sat_inc_16(err_cnt_q);
      end
    end
  end

  assign ready       = (state_q == REQ);
  assign req_timeout = tmo;
  assign out_vld     = out_vld_q;
  assign out_data    = out_data_q;
  assign out_first   = out_first_q;
  assign pkt_done    = done_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_prio    = hdr_q.prio;
  assign pkt_dest    = hdr_q.dest;
  assign len_err     = len_err_q;
  assign dest_err    = dest_err_q;
  assign proto_err   = proto_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule
